// File: rtl/hazard_forward_unit_if.sv
// Hazard/forwarding bundle between the pipeline control and hazard_forward_unit.
// The stats counters appear only when HAZARD_STATS_EN is defined.
interface hazard_forward_unit_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] RS1_D;
    logic [REG_AW-1:0] RS2_D;
    logic [REG_AW-1:0] RS1_E;
    logic [REG_AW-1:0] RS2_E;
    logic [REG_AW-1:0] RD_E;
    logic [REG_AW-1:0] RD_M;
    logic [REG_AW-1:0] RD_W;
    logic              MemReadE;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              PCSrcE;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic              busy;
`ifdef HAZARD_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    modport master (
        output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
        output MemReadE, RegWriteM, RegWriteW, PCSrcE,
        input  ForwardA, ForwardB, StallF, StallD, FlushD, FlushE, busy
`ifdef HAZARD_STATS_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
        input  MemReadE, RegWriteM, RegWriteW, PCSrcE,
        output ForwardA, ForwardB, StallF, StallD, FlushD, FlushE, busy
`ifdef HAZARD_STATS_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX operand forwarding, multi-cycle load-use stall FSM and branch flush control.
// Optional feature macro HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_forward_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_forward_unit_if.slave  hz
);
    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lu;
    logic             stall;
    logic             flush_d;
    logic             flush_e;

    // MEM beats WB; x0 is hard-wired zero and must never be forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && rd_m != '0 && rd_m == rs)      return FWD_MEM;
        else if (we_w && rd_w != '0 && rd_w == rs) return FWD_WB;
        else                                       return FWD_RF;
    endfunction

    assign lu = hz.MemReadE && (hz.RD_E != '0) &&
                ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));

    assign hz.ForwardA = fwd_sel(hz.RS1_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);
    assign hz.ForwardB = fwd_sel(hz.RS2_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        stall   = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (hz.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (state == STALL || lu) begin
            stall   = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.StallF = stall;
    assign hz.StallD = stall;
    assign hz.FlushD = flush_d;
    assign hz.FlushE = flush_e;
    assign hz.busy   = (state == STALL);

    // The IDLE cycle that detects the hazard is stall #1, so STALL covers LOAD_LAT-1 more.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lu && !hz.PCSrcE && MULTI_CYCLE) begin
                        state <= STALL;
                        cnt   <= CNT_LOAD;
                    end else begin
                        cnt   <= '0;
                    end
                end
                STALL: begin
                    if (hz.PCSrcE || cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt - CNT_LAST;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 16'hFFFF)   stall_cnt <= stall_cnt + 16'd1;
            if (flush_d && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
`endif
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline forwarding unit for the 5-stage RISC-V core.
- Combines EX-stage operand forwarding with load-use stall sequencing and branch flush control.
- Supports data memories with multi-cycle load latency via a stall counter FSM.
- Sits beside the pipeline registers. Drives the EX operand mux selects, the F/D stall enables and the D/E flush strobes.

Parameters:
- REG_AW, 5: register address width (number of architectural registers = 2**REG_AW).
- LOAD_LAT, 1: load-use stall cycles required per dependent load; legal range 1..7.
- CNT_W, 3: stall counter width; must satisfy 2**CNT_W > LOAD_LAT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- RS1_D  in  REG_AW  rs1 of instruction in DECODE
- RS2_D  in  REG_AW  rs2 of instruction in DECODE
- RS1_E  in  REG_AW  rs1 of instruction in EXE
- RS2_E  in  REG_AW  rs2 of instruction in EXE
- RD_E  in  REG_AW  rd of instruction in EXE
- RD_M  in  REG_AW  rd in MEM
- RD_W  in  REG_AW  rd in WB
- MemReadE  in  1  EXE instruction is a load
- RegWriteM  in  1  MEM instruction writes rd
- RegWriteW  in  1  WB instruction writes rd
- PCSrcE  in  1  taken branch/jump resolved in EXE
- ForwardA  out  2  rs1 operand select: 00 regfile, 10 MEM, 01 WB
- ForwardB  out  2  rs2 operand select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register (insert bubble)
- busy  out  1  stall FSM not in IDLE

Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.

Behaviour:

Forwarding (combinational, independent of FSM):
- ForwardA = 10 if RegWriteM and RD_M != 0 and RD_M == RS1_E.
- Else ForwardA = 01 if RegWriteW and RD_W != 0 and RD_W == RS1_E.
- Else ForwardA = 00.
- MEM has priority over WB when both match.
- ForwardB uses the same rules with RS2_E.
- x0 is never forwarded.

Load-use detect:
- lu = MemReadE and RD_E != 0 and (RD_E == RS1_D or RD_E == RS2_D).

FSM states: IDLE, STALL. State register and 3-bit counter cnt are reset asynchronously to IDLE / 0.

IDLE:
- If lu and not PCSrcE: StallF = StallD = FlushE = 1 this cycle (combinational).
- If LOAD_LAT > 1: load cnt = LOAD_LAT-1 and go to STALL. Otherwise stay in IDLE.

STALL:
- StallF = StallD = FlushE = 1 every cycle; busy = 1.
- cnt decrements each cycle; return to IDLE on the cycle cnt == 1 (that cycle still stalls).
- lu is ignored in STALL.
- Total stall cycles per hazard = LOAD_LAT exactly.

Branch:
- PCSrcE forces FlushD = FlushE = 1 that cycle and StallF = StallD = 0.
- If PCSrcE and lu occur together, the branch wins: no stall, FSM stays/returns to IDLE, cnt cleared.
- PCSrcE while in STALL cannot occur, since the EXE slot holds a bubble. If it is asserted anyway, the branch wins and the FSM returns to IDLE.

Reset values:
- Reset is asynchronous mid-stall: immediate return to IDLE.
- With all inputs 0: ForwardA/B = 00 and StallF, StallD, FlushD, FlushE, busy = 0.

Optional Feature:
- Macro HAZARD_STATS_EN adds two 16-bit outputs, stall_cnt and flush_cnt.
- stall_cnt increments on each cycle StallD = 1; flush_cnt increments on each cycle FlushD = 1.
- Both saturate at 16'hFFFF and reset to 0 on rst_n.
- Without the macro these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Forward priority: RS1_E=3, RS2_E=4, RD_M=3, RD_W=4, RegWriteM=1, RegWriteW=1 -> ForwardA=10, ForwardB=01. Then RD_M=RD_W=3, RS1_E=3 -> ForwardA=10.
2. x0 guard: RD_M=0, RD_W=0, RS1_E=0, RS2_E=0, both RegWrite=1 -> ForwardA=ForwardB=00.
3. Load-use, LOAD_LAT=1: MemReadE=1, RD_E=5, RS2_D=5 -> exactly 1 cycle of StallF=StallD=FlushE=1; busy stays 0.
4. Load-use, LOAD_LAT=3: same stimulus -> stall 3 consecutive cycles, busy=1 in cycles 2-3, then IDLE. An lu pulse during STALL -> no extension.
5. Branch vs load-use: PCSrcE=1 together with lu -> FlushD=FlushE=1, StallF=StallD=0, busy=0 next cycle.
6. Reset mid-stall: LOAD_LAT=3, assert rst_n=0 in stall cycle 2 -> outputs 0 immediately. With HAZARD_STATS_EN, stall_cnt=0 after release.
